// File: rtl/event_ddr_reader.sv
// Read-only AXI4 master: turns (address, length) commands into 4 KiB-safe bursts and narrows 512-bit beats to 64-bit event words.
// Optional macro EVENT_DDR_READER_RRESP_CHECK_EN enables the sticky rd_err_o read-error flag.
module event_ddr_reader #(
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         memclk,
  input  logic         memreset,
  input  logic [63:0]  s_cmd_tdata,
  input  logic         s_cmd_tvalid,
  output logic         s_cmd_tready,
  output logic [31:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic [2:0]   m_axi_arsize,
  output logic [1:0]   m_axi_arburst,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [511:0] m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rlast,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  output logic [63:0]  m_ev_data_tdata,
  output logic [7:0]   m_ev_data_tkeep,
  output logic         m_ev_data_tlast,
  output logic         m_ev_data_tvalid,
  input  logic         m_ev_data_tready,
  output logic         busy_o,
  output logic         rd_err_o
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic          cmd_ready_reg;
  logic [25:0]   blk_reg;          // next burst address in 64 B units
  logic [14:0]   beats_left_reg;
  logic [17:0]   words_left_reg;
  logic [7:0]    last_keep_reg;
  logic [3:0]    outstanding_reg;
  logic          ar_valid_reg;
  logic [25:0]   ar_blk_reg;
  logic [7:0]    ar_len_reg;
  logic [511:0]  hold_reg;
  logic          hold_full_reg;
  logic [2:0]    idx_reg;
  logic          tlast_seen_reg;
  logic          rd_err_reg;

  logic          cmd_hs, ar_hs, r_hs, rlast_hs, out_hs, tlast_hs;
  logic          is_last_word, ar_launch, run_done;
  logic [19:0]   cmd_len;
  logic [14:0]   cmd_beats;
  logic [17:0]   cmd_words;
  logic [7:0]    cmd_keep;
  logic [6:0]    page_beats;
  logic [14:0]   burst;
  logic [63:0]   words [8];
  logic          unused_bits;

  assign cmd_len      = s_cmd_tdata[51:32];
  assign cmd_beats    = 15'((21'(cmd_len) + 21'd63) >> 6);
  assign cmd_words    = 18'((21'(cmd_len) + 21'd7) >> 3);
  assign cmd_keep     = (cmd_len[2:0] == 3'd0) ? 8'hFF : 8'((8'h01 << cmd_len[2:0]) - 8'h01);
  assign unused_bits  = ^{s_cmd_tdata[63:52], s_cmd_tdata[5:0], m_axi_rresp};

  assign cmd_hs       = s_cmd_tvalid && cmd_ready_reg;
  assign ar_hs        = ar_valid_reg && m_axi_arready;
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign rlast_hs     = r_hs && m_axi_rlast;
  assign out_hs       = hold_full_reg && m_ev_data_tready;
  assign is_last_word = (words_left_reg == 18'd1);
  assign tlast_hs     = out_hs && is_last_word;
  assign run_done     = (tlast_seen_reg || tlast_hs) && (outstanding_reg == 4'd0) &&
                        (beats_left_reg == 15'd0) && !ar_valid_reg;

  assign ar_launch = (state_reg == RUN) && !ar_valid_reg && (beats_left_reg != 15'd0) &&
                     (outstanding_reg < 4'(MAX_OUTSTANDING));

  // Beats left before the 4 KiB page ends: 1..64.
  assign page_beats = 7'd64 - 7'(blk_reg[5:0]);

  always_comb begin
    burst = beats_left_reg;
    if (burst > 15'(MAX_BURST)) burst = 15'(MAX_BURST);
    if (burst > 15'(page_beats)) burst = 15'(page_beats);
  end

  always_ff @(posedge memclk) begin
    if (memreset) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cmd_hs && (cmd_len != 20'd0)) state_next = RUN;
      RUN:  if (run_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge memclk) begin
    if (memreset) begin
      cmd_ready_reg   <= 1'b0;
      blk_reg         <= '0;
      beats_left_reg  <= '0;
      words_left_reg  <= '0;
      last_keep_reg   <= 8'hFF;
      outstanding_reg <= '0;
      ar_valid_reg    <= 1'b0;
      ar_blk_reg      <= '0;
      ar_len_reg      <= '0;
      hold_full_reg   <= 1'b0;
      idx_reg         <= '0;
      tlast_seen_reg  <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == IDLE);

      if (cmd_hs) begin
        blk_reg        <= s_cmd_tdata[31:6];
        beats_left_reg <= cmd_beats;
        words_left_reg <= cmd_words;
        last_keep_reg  <= cmd_keep;
        tlast_seen_reg <= 1'b0;
      end else begin
        if (ar_launch) begin
          ar_valid_reg <= 1'b1;
          ar_blk_reg   <= blk_reg;
          ar_len_reg   <= 8'(burst - 15'd1);
        end
        if (ar_hs) begin
          ar_valid_reg   <= 1'b0;
          blk_reg        <= blk_reg + 26'(ar_len_reg) + 26'd1;
          beats_left_reg <= beats_left_reg - (15'(ar_len_reg) + 15'd1);
        end
        if (tlast_hs) tlast_seen_reg <= 1'b1;
      end

      case ({ar_hs, rlast_hs})
        2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
        2'b01:   outstanding_reg <= outstanding_reg - 4'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase

      // rready is only high while the holding register is empty, so load and drain never overlap.
      if (r_hs) begin
        hold_full_reg <= 1'b1;
        idx_reg       <= 3'd0;
      end
      if (out_hs) begin
        words_left_reg <= words_left_reg - 18'd1;
        if (is_last_word || (idx_reg == 3'd7)) hold_full_reg <= 1'b0;
        else                                   idx_reg       <= idx_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge memclk) begin
    if (r_hs) hold_reg <= m_axi_rdata;
  end

`ifdef EVENT_DDR_READER_RRESP_CHECK_EN
  always_ff @(posedge memclk) begin
    if (memreset)                           rd_err_reg <= 1'b0;
    else if (cmd_hs)                        rd_err_reg <= 1'b0;
    else if (r_hs && (m_axi_rresp != 2'b00)) rd_err_reg <= 1'b1;
  end
`else
  assign rd_err_reg = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign words[gi] = hold_reg[gi*64 +: 64];
    end
  endgenerate

  assign s_cmd_tready     = cmd_ready_reg;
  assign m_axi_araddr     = {ar_blk_reg, 6'b0};
  assign m_axi_arlen      = ar_len_reg;
  assign m_axi_arsize     = 3'd6;
  assign m_axi_arburst    = 2'b01;
  assign m_axi_arvalid    = ar_valid_reg;
  assign m_axi_rready     = (state_reg == RUN) && !hold_full_reg;
  assign m_ev_data_tdata  = words[idx_reg];
  assign m_ev_data_tkeep  = is_last_word ? last_keep_reg : 8'hFF;
  assign m_ev_data_tlast  = hold_full_reg && is_last_word;
  assign m_ev_data_tvalid = hold_full_reg;
  assign busy_o           = (state_reg == RUN);
  assign rd_err_o         = rd_err_reg;

endmodule

// File: tb/tb_event_ddr_reader.sv
// Bench for event_ddr_reader: a DDR/AXI slave model plus a command-level model of the expected bursts and words.
`timescale 1ns/1ps
module tb_event_ddr_reader;
  localparam int MAXB = 16;
  localparam int MAXO = 4;

  logic         memclk = 1'b0;
  logic         memreset = 1'b1;
  logic [63:0]  s_cmd_tdata = '0;
  logic         s_cmd_tvalid = 1'b0;
  logic         s_cmd_tready;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b1;
  logic [511:0] m_axi_rdata = '0;
  logic [1:0]   m_axi_rresp = 2'b00;
  logic         m_axi_rlast = 1'b0;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [63:0]  m_ev_data_tdata;
  logic [7:0]   m_ev_data_tkeep;
  logic         m_ev_data_tlast;
  logic         m_ev_data_tvalid;
  logic         m_ev_data_tready = 1'b1;
  logic         busy_o;
  logic         rd_err_o;

  always #5 memclk = ~memclk;

  event_ddr_reader #(.MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO)) dut (
    .memclk(memclk), .memreset(memreset),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_ev_data_tdata(m_ev_data_tdata), .m_ev_data_tkeep(m_ev_data_tkeep),
    .m_ev_data_tlast(m_ev_data_tlast), .m_ev_data_tvalid(m_ev_data_tvalid),
    .m_ev_data_tready(m_ev_data_tready), .busy_o(busy_o), .rd_err_o(rd_err_o)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; } word_t;

  ar_t   exp_ar_q[$], pend_q[$], ar_log[$];
  word_t exp_w_q[$];
  int    tests = 0, fails = 0;
  int    words_seen = 0, outstanding_tb = 0, beat_idx = 0, beat_total = 0;
  int    err_beat = -1;
  bit    rand_mode = 1'b0;
  logic [7:0] last_keep_seen = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents are a pure function of address, so any misplaced word is visible.
  function automatic logic [63:0] mem_word(input logic [31:0] a, input int w);
    return {a, 8'(w), 24'hC0FFEE};
  endfunction

  function automatic logic [511:0] mem_beat(input logic [31:0] a);
    logic [511:0] b;
    for (int w = 0; w < 8; w++) b[w*64 +: 64] = mem_word(a, w);
    return b;
  endfunction

  task automatic model_cmd(input logic [31:0] a, input int len);
    int base, nb, nw, n, bytes, cur;
    word_t wd;
    ar_t ar;
    base = int'({a[31:6], 6'b0});
    nb = (len + 63) / 64;
    nw = (len + 7) / 8;
    cur = base;
    while (nb > 0) begin
      n = nb;
      if (n > MAXB) n = MAXB;
      if (n > (4096 - (cur % 4096)) / 64) n = (4096 - (cur % 4096)) / 64;
      ar.addr = 32'(cur);
      ar.len = 8'(n - 1);
      exp_ar_q.push_back(ar);
      cur += 64 * n;
      nb -= n;
    end
    for (int i = 0; i < nw; i++) begin
      bytes = (i == nw - 1) ? len - 8 * i : 8;
      wd.data = mem_word(32'(base + 64 * (i / 8)), i % 8);
      wd.keep = 8'((1 << bytes) - 1);
      wd.last = (i == nw - 1);
      exp_w_q.push_back(wd);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input int len);
    int n;
    model_cmd(a, len);
    beat_total = 0;
    @(posedge memclk); #1;
    s_cmd_tdata = {12'h0, 20'(len), a};
    s_cmd_tvalid = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge memclk);
      if (s_cmd_tready) break;
      n++;
    end
    check("cmd_accept_timeout", 64'(n < 100), 64'd1);
    @(posedge memclk); #1;
    s_cmd_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_w_q.size() != 0 || exp_ar_q.size() != 0 || busy_o) && n < budget) begin
      @(negedge memclk);
      n++;
    end
    check("done_timeout", 64'(n < budget), 64'd1);
  endtask

  // Slave model and per-cycle comparison against the command model.
  initial begin
    bit hold_d, hold_a, chk_busy, chk_err;
    word_t prev_w, e;
    ar_t prev_a, ea, got_a;
    hold_d = 0; hold_a = 0; chk_busy = 0; chk_err = 0;
    forever begin
      @(negedge memclk);
      if (memreset) begin
        pend_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
        outstanding_tb = 0; beat_idx = 0; beat_total = 0;
        hold_d = 0; hold_a = 0; chk_busy = 0; chk_err = 0;
      end else begin
        if (chk_busy) begin
          check("busy_drop", 64'(busy_o), 64'd0);
          check("ready_after_done", 64'(s_cmd_tready), 64'd1);
          chk_busy = 0;
        end
        if (chk_err) begin
          check("rd_err_set", 64'(rd_err_o), 64'd1);
          chk_err = 0;
        end
        if (hold_d) begin
          check("out_hold_valid", 64'(m_ev_data_tvalid), 64'd1);
          check("out_hold_word", 64'({m_ev_data_tkeep, m_ev_data_tlast, m_ev_data_tdata[54:0]}),
                64'({prev_w.keep, prev_w.last, prev_w.data[54:0]}));
        end
        if (hold_a) begin
          check("ar_hold", 64'({m_axi_arvalid, m_axi_araddr, m_axi_arlen}),
                64'({1'b1, prev_a.addr, prev_a.len}));
        end
        if (m_axi_arvalid && m_axi_arready) begin
          got_a.addr = m_axi_araddr;
          got_a.len = m_axi_arlen;
          check("ar_const", 64'({m_axi_arsize, m_axi_arburst}), 64'({3'd6, 2'b01}));
          if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(got_a), 64'hFFFF_FFFF_FFFF);
          else begin
            ea = exp_ar_q.pop_front();
            check("ar_addr_len", 64'(got_a), 64'(ea));
          end
          pend_q.push_back(got_a);
          ar_log.push_back(got_a);
          outstanding_tb++;
          check("max_outstanding", 64'(outstanding_tb <= MAXO), 64'd1);
        end
        if (m_ev_data_tvalid && m_ev_data_tready) begin
          if (exp_w_q.size() == 0) check("word_unexpected", m_ev_data_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
          else begin
            e = exp_w_q.pop_front();
            check("tdata", m_ev_data_tdata, e.data);
            check("tkeep_tlast", 64'({m_ev_data_tkeep, m_ev_data_tlast}), 64'({e.keep, e.last}));
            if (e.last && exp_w_q.size() == 0) chk_busy = 1;
          end
          words_seen++;
          last_keep_seen = m_ev_data_tkeep;
        end
        if (m_axi_rvalid && m_axi_rready && pend_q.size() > 0) begin
`ifdef EVENT_DDR_READER_RRESP_CHECK_EN
          if (beat_total == err_beat) chk_err = 1;
`endif
          beat_total++;
          if (m_axi_rlast) begin
            void'(pend_q.pop_front());
            beat_idx = 0;
            outstanding_tb--;
          end else beat_idx++;
        end
        hold_d = m_ev_data_tvalid && !m_ev_data_tready;
        prev_w.data = m_ev_data_tdata; prev_w.keep = m_ev_data_tkeep; prev_w.last = m_ev_data_tlast;
        hold_a = m_axi_arvalid && !m_axi_arready;
        prev_a.addr = m_axi_araddr; prev_a.len = m_axi_arlen;
      end
      @(posedge memclk); #1;
      m_axi_arready    = rand_mode ? 1'($urandom % 2) : 1'b1;
      m_ev_data_tready = rand_mode ? 1'($urandom % 2) : 1'b1;
      if (pend_q.size() > 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_beat(pend_q[0].addr + 32'(64 * beat_idx));
        m_axi_rlast  = (beat_idx == int'(pend_q[0].len));
        m_axi_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  end

  initial begin
    int w0, a0, n;
    repeat (3) @(posedge memclk);
    @(negedge memclk);
    check("rst_outputs", 64'({s_cmd_tready, m_axi_arvalid, m_axi_rready, m_ev_data_tvalid, busy_o, rd_err_o}), 64'd0);
    @(posedge memclk); #1;
    memreset = 1'b0;
    @(negedge memclk);
    @(negedge memclk);
    check("rst_cmd_ready", 64'(s_cmd_tready), 64'd1);

    // One full beat.
    w0 = words_seen; a0 = ar_log.size();
    send_cmd(32'h1000, 64); wait_done(500);
    check("t1_words", 64'(words_seen - w0), 64'd8);
    check("t1_ar_count", 64'(ar_log.size() - a0), 64'd1);
    check("t1_ar0", 64'(ar_log[a0]), 64'({32'h1000, 8'd0}));

    // Partial last word; words 3..7 of the beat are discarded.
    w0 = words_seen; a0 = ar_log.size();
    send_cmd(32'h2000, 20); wait_done(500);
    check("t2_words", 64'(words_seen - w0), 64'd3);
    check("t2_last_keep", 64'(last_keep_seen), 64'h0F);
    check("t2_ar_count", 64'(ar_log.size() - a0), 64'd1);

    // 4 KiB page crossing splits the read.
    w0 = words_seen; a0 = ar_log.size();
    send_cmd(32'h0FC0, 256); wait_done(500);
    check("t3_words", 64'(words_seen - w0), 64'd32);
    check("t3_ar_count", 64'(ar_log.size() - a0), 64'd2);
    check("t3_ar0", 64'(ar_log[a0]), 64'({32'h0FC0, 8'd0}));
    check("t3_ar1", 64'(ar_log[a0 + 1]), 64'({32'h1000, 8'd2}));

    // Full page with random backpressure on AR and output.
    rand_mode = 1'b1;
    w0 = words_seen; a0 = ar_log.size();
    send_cmd(32'h0, 4096); wait_done(5000);
    rand_mode = 1'b0;
    check("t4_words", 64'(words_seen - w0), 64'd512);
    check("t4_ar_count", 64'(ar_log.size() - a0), 64'd4);
    for (int i = 0; i < 4; i++)
      check("t4_ar", 64'(ar_log[a0 + i]), 64'({32'(i * 1024), 8'd15}));

    // Zero length is consumed silently; then a single word.
    w0 = words_seen; a0 = ar_log.size();
    send_cmd(32'h40, 0);
    repeat (5) @(negedge memclk);
    check("t5_len0_busy", 64'(busy_o), 64'd0);
    check("t5_len0_noar", 64'(ar_log.size() - a0), 64'd0);
    check("t5_len0_nowords", 64'(words_seen - w0), 64'd0);
    send_cmd(32'h5000, 8); wait_done(500);
    check("t5_words", 64'(words_seen - w0), 64'd1);
    check("t5_last_keep", 64'(last_keep_seen), 64'hFF);

`ifdef EVENT_DDR_READER_RRESP_CHECK_EN
    err_beat = 1;
    w0 = words_seen;
    send_cmd(32'h3000, 256); wait_done(500);
    err_beat = -1;
    check("t6_words", 64'(words_seen - w0), 64'd32);
    check("t6_err_sticky", 64'(rd_err_o), 64'd1);
    send_cmd(32'h3400, 64);
    @(negedge memclk);
    check("t6_err_cleared", 64'(rd_err_o), 64'd0);
    wait_done(500);
`else
    check("t6_err_tied", 64'(rd_err_o), 64'd0);
`endif

    // Reset in the middle of a command, then recover.
    w0 = words_seen;
    send_cmd(32'h8000, 1024);
    n = 0;
    while (words_seen - w0 < 5 && n < 500) begin @(negedge memclk); n++; end
    check("t7_started", 64'(n < 500), 64'd1);
    @(posedge memclk); #1;
    memreset = 1'b1;
    repeat (2) @(negedge memclk);
    check("t7_rst_outputs", 64'({s_cmd_tready, m_axi_arvalid, m_axi_rready, m_ev_data_tvalid, busy_o}), 64'd0);
    @(posedge memclk); #1;
    memreset = 1'b0;
    w0 = words_seen; a0 = ar_log.size();
    send_cmd(32'h9000, 64); wait_done(500);
    check("t7_words", 64'(words_seen - w0), 64'd8);
    check("t7_ar0", 64'(ar_log[a0]), 64'({32'h9000, 8'd0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
